serial_frame_shifter: RTL and testbench
=======================================

// Module: serial_frame_shifter
// PURPOSE
//  Parallel-to-serial front end for the serial pattern-detector path. Accepts a
//  DATA_WIDTH word over a load/ready handshake and emits it one bit per shift
//  strobe on serial_out, which drives the detector's serial input bit by bit.
//  A free-running or divided shift_en sets the bit rate; status flags frame it.
// PARAMETERS
//  DATA_WIDTH  8  word width, >= 2
//  MSB_FIRST   1  1: bit DATA_WIDTH-1 sent first; 0: bit 0 sent first
//  IDLE_BIT    0  serial_out level when no frame is active
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           synchronous reset, active-high
//  par_data    in   DATA_WIDTH  word to serialize, sampled when load & ready
//  load        in   1           word-valid request
//  shift_en    in   1           bit-advance strobe (one bit per high cycle)
//  ready       out  1           1 = can accept a word this cycle
//  serial_out  out  1           registered serial bit stream
//  bit_valid   out  1           1 = serial_out carries a frame bit
//  done        out  1           1-cycle pulse after the final bit is consumed
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high (rst). On rst:
//    state=IDLE, ready=1, serial_out=IDLE_BIT, bit_valid=0, done=0, counter=0.
//  - rst mid-frame aborts immediately; captured word discarded, no done pulse.
//  - States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_EN).
//  - IDLE: ready=1 (combinational from state). load=1 -> capture par_data into
//    shift register, bit_cnt<=0, serial_out<=first bit, bit_valid<=1, go SHIFT.
//    shift_en in IDLE is ignored.
//  - SHIFT: ready=0; load ignored (no capture, no queuing). serial_out holds
//    until shift_en=1. On shift_en with bit_cnt<DATA_WIDTH-1: serial_out<=next
//    bit, bit_cnt++. On shift_en with bit_cnt==DATA_WIDTH-1: end of data.
//  - End of data without PARITY_EN: state<=IDLE, serial_out<=IDLE_BIT,
//    bit_valid<=0, done<=1 for exactly one cycle.
//  - Latency: capture edge -> first bit visible next cycle; each bit lasts from
//    the edge that presents it to the edge sampling the shift_en consuming it.
//  - Back-to-back: ready returns 1 in the cycle done=1; a load then is accepted,
//    giving zero idle bits between frames. load coincident with the final
//    shift_en is not accepted (ready=0 that cycle).
//  - bit_cnt width = $clog2(DATA_WIDTH); never wraps past DATA_WIDTH-1.
//  - Illegal state encodings decode to IDLE with IDLE outputs.
// CONFIGURATION
//  Macro SERIAL_FRAME_SHIFTER_PARITY_EN:
//  - Defined: at end of data go PARITY, serial_out<=^word (even parity:
//    ones count incl. parity bit is even), bit_valid stays 1; next shift_en ->
//    IDLE, serial_out<=IDLE_BIT, bit_valid<=0, done pulse. Frame = DATA_WIDTH+1.
//  - Undefined: PARITY state and parity logic absent; frame = DATA_WIDTH bits.
// TESTING
//  1. rst=1 two cycles mid-activity -> ready=1, serial_out=0, bit_valid=0,
//     done=0 on the cycle after the first rst edge.
//  2. Defaults, load 8'b1101_1010, shift_en=1 always -> serial_out
//     1,1,0,1,1,0,1,0 on 8 consecutive cycles, then done=1 one cycle,
//     serial_out=0; downstream detector o=1 once (after bits 1,1,0,1).
//  3. shift_en high every 3rd cycle, load 8'hA5 -> each bit held 3 cycles,
//     bit_valid high 24 cycles, done once.
//  4. load=1 with par_data=8'hFF during SHIFT of 8'h0F -> 8'hFF never sent;
//     stream is 0,0,0,0,1,1,1,1; second load accepted in the done cycle.
//  5. rst after 3 bits of 8'hC3 -> IDLE next cycle, no done; new load 8'h81
//     sends 1,0,0,0,0,0,0,1 cleanly.
//  6. MSB_FIRST=0, PARITY_EN defined, load 8'hD3 -> 1,1,0,0,1,0,1,1 then
//     parity 1, done after 9 shifts.

Source files
------------

// File: rtl/serial_frame_shifter.sv
// -----------------------------------------------------------------------------
// serial_frame_shifter
// Parallel-to-serial front end: accepts a DATA_WIDTH word over a load/ready
// handshake and emits it one bit per shift_en strobe on a registered
// serial_out. bit_valid frames the data bits and done pulses once after the
// final bit has been consumed.
//
// Optional feature macro: SERIAL_FRAME_SHIFTER_PARITY_EN
//   defined   -> an even-parity bit is appended (frame = DATA_WIDTH+1 bits)
//   undefined -> frame = DATA_WIDTH bits, no parity state or logic
// -----------------------------------------------------------------------------
module serial_frame_shifter #(
  parameter int   DATA_WIDTH = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] par_data,
  input  logic                  load,
  input  logic                  shift_en,
  output logic                  ready,
  output logic                  serial_out,
  output logic                  bit_valid,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Encoding 2'b11 (and 2'b10 without parity) is illegal and decodes as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
    ST_PARITY = 2'b10,
`endif
    ST_SHIFT  = 2'b01
  } state_t;

  state_t                state_q,      state_d;
  logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic                  serial_out_q, serial_out_d;
  logic                  bit_valid_q,  bit_valid_d;
  logic                  done_q,       done_d;
  logic                  ready_s;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
  logic                  parity_q,     parity_d;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Bit presented first from a freshly captured word.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word);
    logic b;
    if (MSB_FIRST != 0) begin
      b = word[DATA_WIDTH-1];
    end else begin
      b = word[0];
    end
    return b;
  endfunction

  // Next-state, datapath and output decode; IDLE doubles as the illegal-state catch-all.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    serial_out_d = serial_out_q;
    bit_valid_d  = bit_valid_q;
    done_d       = 1'b0;
    ready_s      = 1'b0;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        if (shift_en) begin
          if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_d = CNT_ZERO;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
            state_d      = ST_PARITY;
            serial_out_d = parity_q;
            bit_valid_d  = 1'b1;
`else
            state_d      = ST_IDLE;
            serial_out_d = IDLE_BIT;
            bit_valid_d  = 1'b0;
            done_d       = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            // Shift the sent bit out so the next one is always at a fixed index.
            if (MSB_FIRST != 0) begin
              shreg_d      = {shreg_q[DATA_WIDTH-2:0], 1'b0};
              serial_out_d = shreg_q[DATA_WIDTH-2];
            end else begin
              shreg_d      = {1'b0, shreg_q[DATA_WIDTH-1:1]};
              serial_out_d = shreg_q[1];
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
      ST_PARITY: begin
        if (shift_en) begin
          state_d      = ST_IDLE;
          serial_out_d = IDLE_BIT;
          bit_valid_d  = 1'b0;
          done_d       = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      default: begin
        ready_s      = 1'b1;
        state_d      = ST_IDLE;
        bit_cnt_d    = CNT_ZERO;
        serial_out_d = IDLE_BIT;
        bit_valid_d  = 1'b0;
        if (load) begin
          shreg_d      = par_data;
          serial_out_d = first_bit(par_data);
          bit_valid_d  = 1'b1;
          state_d      = ST_SHIFT;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
          parity_d     = even_parity(par_data);
`endif
        end else begin
          shreg_d = shreg_q;
        end
      end
    endcase
  end

  // State and datapath registers; rst aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= {DATA_WIDTH{1'b0}};
      bit_cnt_q    <= CNT_ZERO;
      serial_out_q <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      done_q       <= done_d;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ready      = ready_s;
  assign serial_out = serial_out_q;
  assign bit_valid  = bit_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_shifter
// Two instances (MSB-first and LSB-first) share one stimulus stream. A cycle
// model at the falling edge tracks frame activity; expected bits are queued
// when a load is accepted and popped as shift_en consumes them.
// -----------------------------------------------------------------------------
module tb_serial_frame_shifter;

`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] par_data;
  logic          load;
  logic          shift_en;
  logic          ready_m, serial_out_m, bit_valid_m, done_m;
  logic          ready_l, serial_out_l, bit_valid_l, done_l;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int bv_cycles = 0;
  bit mon_en = 1'b0;

  // model state
  bit   m_active = 1'b0;
  bit   exp_done = 1'b0;
  logic q_m[$];
  logic q_l[$];

  serial_frame_shifter #(.DATA_WIDTH(DW), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut_msb (
    .clk(clk), .rst(rst), .par_data(par_data), .load(load), .shift_en(shift_en),
    .ready(ready_m), .serial_out(serial_out_m), .bit_valid(bit_valid_m), .done(done_m)
  );

  serial_frame_shifter #(.DATA_WIDTH(DW), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .par_data(par_data), .load(load), .shift_en(shift_en),
    .ready(ready_l), .serial_out(serial_out_l), .bit_valid(bit_valid_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      q_m.push_back(w[DW-1-i]);
      q_l.push_back(w[i]);
    end
    if (PAR_EN != 0) begin
      q_m.push_back(^w);
      q_l.push_back(^w);
    end
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, (done_cnt != start), 1'b1);
  endtask

  // Falling-edge monitor and reference model
  initial begin
    bit nxt_done;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_eq("done_m", done_m, exp_done);
        check_eq("done_l", done_l, exp_done);
        check_eq("ready_m", ready_m, !m_active);
        check_eq("ready_l", ready_l, !m_active);
        check_eq("bit_valid_m", bit_valid_m, m_active);
        check_eq("bit_valid_l", bit_valid_l, m_active);
        if (m_active && q_m.size() > 0) begin
          check_eq("serial_m", serial_out_m, q_m[0]);
          check_eq("serial_l", serial_out_l, q_l[0]);
        end else begin
          check_eq("idle_m", serial_out_m, 1'b0);
          check_eq("idle_l", serial_out_l, 1'b0);
        end
        if (done_m) done_cnt++;
        if (bit_valid_m) bv_cycles++;
        nxt_done = 1'b0;
        if (rst) begin
          m_active = 1'b0;
          q_m.delete();
          q_l.delete();
        end else if (m_active) begin
          if (shift_en && q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            if (q_m.size() == 0) begin
              m_active = 1'b0;
              nxt_done = 1'b1;
            end
          end
        end else if (load) begin
          push_word(par_data);
          m_active = 1'b1;
        end
        exp_done = nxt_done;
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1; load = 1'b0; shift_en = 1'b0; par_data = '0;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Continuous shifting, 8'b1101_1010
    par_data = 8'b1101_1010; load = 1'b1; shift_en = 1'b1;
    step();
    load = 1'b0;
    wait_frame("t2_done", 40);
    step(); step();

    // shift_en every third cycle, 8'hA5
    shift_en = 1'b0; par_data = 8'hA5; load = 1'b1;
    step();
    load = 1'b0;
    bv_cycles = 0;
    d0 = done_cnt;
    for (int k = 0; k < 60 && done_cnt == d0; k++) begin
      shift_en = ((k % 3) == 2);
      step();
    end
    shift_en = 1'b0;
    step();
    check_eq("t3_bv_cycles", bv_cycles, 24 + 3 * PAR_EN);
    check_eq("t3_done_cnt", done_cnt - d0, 1);

    // load ignored mid-frame, second load in the done cycle
    par_data = 8'h0F; load = 1'b1; shift_en = 1'b1;
    step();
    par_data = 8'hFF;
    repeat (5) step();
    load = 1'b0;
    for (int i = 0; i < 40 && !done_m; i++) step();
    check_eq("t4_done_seen", done_m, 1'b1);
    par_data = 8'h3C; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("t4_second", 40);
    step();

    // Two-cycle rst after three bits of 8'hC3, then 8'h81
    par_data = 8'hC3; load = 1'b1; shift_en = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    d0 = done_cnt;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    check_eq("t5_no_done", done_cnt - d0, 0);
    par_data = 8'h81; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("t5_frame", 40);
    step();

    // Random load / shift_en / data traffic
    for (int c = 0; c < 400; c++) begin
      shift_en = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 3) == 0);
      par_data = DW'($urandom);
      step();
    end
    load = 1'b0; shift_en = 1'b1;
    repeat (20) step();
    check_eq("drain_ready", ready_m, 1'b1);
    check_eq("drain_queue", q_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
